palindrome_gen: RTL

//  Transmit-side counterpart of the palindrome checker: accepts a half-width seed over a

---
 rtl/palindrome_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/palindrome_gen.sv
// -----------------------------------------------------------------------------
// palindrome_gen
//   Transmit-side palindrome builder. Accepts a half-width seed over a
//   valid/ready handshake, forms the Data_width-bit palindrome
//   {bitrev(seed), seed}, presents it once in parallel (word_valid pulse), then
//   serialises it MSB-first over a valid/ready/last bit stream.
//
// Parameters
//   Data_width  palindrome word width (even, >= 2); seed width is Data_width/2
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   seed_valid  in   seed_data valid
//   seed_ready  out  block can accept a seed (high in IDLE)
//   seed_data   in   half-word seed
//   word_valid  out  one-cycle pulse: word_data holds a new palindrome
//   word_data   out  registered palindrome word, held until next seed accept
//   ser_valid   out  ser_data valid (never drops mid-word)
//   ser_ready   in   downstream accepts current bit
//   ser_data    out  serial bit, MSB first
//   ser_last    out  high with the final bit (word bit 0)
//   word_count  out  words fully sent, wraps at 16 bits
//                    (present only when PAL_GEN_CNT_EN is defined)
//
// Configuration
//   PAL_GEN_CNT_EN  defined: adds the word_count port and its counter.
// -----------------------------------------------------------------------------
module palindrome_gen #(
  parameter int Data_width = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [Data_width/2-1:0] seed_data,
  output logic                    word_valid,
  output logic [Data_width-1:0]   word_data,
  output logic                    ser_valid,
  input  logic                    ser_ready,
  output logic                    ser_data,
  output logic                    ser_last
`ifdef PAL_GEN_CNT_EN
  ,
  output logic [15:0]             word_count
`endif
);

  localparam int Half   = Data_width / 2;
  localparam int Cnt_w  = $clog2(Data_width);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [Data_width-1:0] word_data_q, word_data_d;
  logic [Data_width-1:0] shift_q, shift_d;
  logic [Cnt_w-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  word_valid_q, word_valid_d;
  logic [Data_width-1:0] built_word;
  logic                  seed_accept;
  logic                  bit_xfer;
  logic                  last_xfer;

  // Lower half is the seed itself, upper half its bit-reverse, so
  // word[i] == word[Data_width-1-i] for every i.
  always_comb begin
    built_word = '0;
    for (int i = 0; i < Half; i++) begin
      built_word[i]                = seed_data[i];
      built_word[Data_width-1-i]   = seed_data[i];
    end
  end

  assign seed_accept = (state_q == IDLE) && seed_valid;
  assign bit_xfer    = (state_q == SHIFT) && ser_ready;
  assign last_xfer   = bit_xfer && (bit_cnt_q == '0);

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    word_data_d  = word_data_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (seed_accept) begin
          word_data_d  = built_word;
          shift_d      = built_word;
          bit_cnt_d    = Cnt_w'(Data_width - 1);
          word_valid_d = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        // Backpressure (ser_ready low) leaves shift register and counter as-is,
        // which keeps ser_data and ser_last stable.
        if (bit_xfer) begin
          shift_d = shift_q << 1;
          if (bit_cnt_q == '0) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_data_q  <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_data_q  <= word_data_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign seed_ready = (state_q == IDLE);
  assign ser_valid  = (state_q == SHIFT);
  // Gated by state so the line idles low between words.
  assign ser_data   = (state_q == SHIFT) && shift_q[Data_width-1];
  assign ser_last   = (state_q == SHIFT) && (bit_cnt_q == '0);
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;

`ifdef PAL_GEN_CNT_EN
  logic [15:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (last_xfer) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`else
  // last_xfer only feeds the optional word counter.
  logic unused_last_xfer;
  assign unused_last_xfer = last_xfer;
`endif

endmodule
